// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that time-shares one combinational ALU.
// Operands are registered, held for EXEC_CYCLES, then the result is returned with the requester ID.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  id_q, id_d;

    logic grant;
    logic accept;

    // With both requesting, the one not served last time wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = !reset && (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = !reset && (state_q == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        zero_d       = zero_q;
        id_d         = id_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = grant ? req1_op : req0_op;
                    a_d          = grant ? req1_a  : req0_a;
                    b_d          = grant ? req1_b  : req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = CNT_INIT;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            id_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            id_q         <= id_d;
        end
    end

    // ALU inputs come only from the operand registers, so they hold through IDLE and RESP.
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3,
// each driving a behavioural ALU model.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural ALU; MULTPLUS is modelled as a*b+a, it is never exercised here.
    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return ~(a | b);
            4'b0011: return a + b;
            4'b0100: return a - b;
            4'b0101: return a + 32'd1;
            4'b0110: return a * b + a;
            4'b0111: return b;
            4'b1000: return a + b;
            default: return '0;
        endcase
    endfunction

    // EXEC_CYCLES = 1 instance
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic [OW-1:0] r0_op, r1_op, a_op;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b, a_a, a_b, a_res, rsp_result;
    logic          a_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

    assign a_res  = alu_f(a_op, a_a, a_b);
    assign a_zero = (a_res == '0);

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .EXEC_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
        .alu_op(a_op), .alu_a(a_a), .alu_b(a_b), .alu_result(a_res), .alu_zero(a_zero),
        .resp_valid(rsp_valid), .resp_ready(rsp_ready), .resp_id(rsp_id),
        .resp_result(rsp_result), .resp_zero(rsp_zero)
    );

    // EXEC_CYCLES = 3 instance, requester 1 idle
    logic          s0_valid, s0_ready, s1_valid, s1_ready;
    logic [OW-1:0] s0_op, s1_op, b_op;
    logic [DW-1:0] s0_a, s0_b, s1_a, s1_b, b_a, b_b, b_res, srsp_result;
    logic          b_zero, srsp_valid, srsp_ready, srsp_id, srsp_zero;

    assign b_res  = alu_f(b_op, b_a, b_b);
    assign b_zero = (b_res == '0);

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(s0_valid), .req0_ready(s0_ready), .req0_op(s0_op), .req0_a(s0_a), .req0_b(s0_b),
        .req1_valid(s1_valid), .req1_ready(s1_ready), .req1_op(s1_op), .req1_a(s1_a), .req1_b(s1_b),
        .alu_op(b_op), .alu_a(b_a), .alu_b(b_b), .alu_result(b_res), .alu_zero(b_zero),
        .resp_valid(srsp_valid), .resp_ready(srsp_ready), .resp_id(srsp_id),
        .resp_result(srsp_result), .resp_zero(srsp_zero)
    );

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        r0_valid   = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
        r1_valid   = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;
        rsp_ready  = 1'b0;
        s0_valid   = 1'b0; s0_op = '0; s0_a = '0; s0_b = '0;
        s1_valid   = 1'b0; s1_op = '0; s1_a = '0; s1_b = '0;
        srsp_ready = 1'b0;

        tick(); tick();
        check("rst_resp_valid", rsp_valid, 0);
        check("rst_resp_result", rsp_result, 0);
        check("rst_alu_op", a_op, 0);
        check("rst_alu_a", a_a, 0);
        reset = 1'b0;
        tick();

        // 1: single ADD from requester 0
        r0_valid = 1'b1; r0_op = 4'b0011; r0_a = 32'd5; r0_b = 32'd7;
        #1;
        check("t1_req0_ready", r0_ready, 1);
        check("t1_req1_ready", r1_ready, 0);
        tick();
        r0_valid = 1'b0;
        check("t1_exec_valid", rsp_valid, 0);
        check("t1_alu_a", a_a, 32'd5);
        check("t1_alu_op", a_op, 4'b0011);
        tick();
        check("t1_resp_valid", rsp_valid, 1);
        check("t1_resp_id", rsp_id, 0);
        check("t1_resp_result", rsp_result, 32'd12);
        check("t1_resp_zero", rsp_zero, 0);
        rsp_ready = 1'b1;
        tick();
        check("t1_consumed", rsp_valid, 0);

        // 2: SUB to zero from requester 1
        r1_valid = 1'b1; r1_op = 4'b0100; r1_a = 32'd9; r1_b = 32'd9;
        #1;
        check("t2_req1_ready", r1_ready, 1);
        tick();
        r1_valid = 1'b0;
        tick();
        check("t2_resp_valid", rsp_valid, 1);
        check("t2_resp_result", rsp_result, 0);
        check("t2_resp_zero", rsp_zero, 1);
        check("t2_resp_id", rsp_id, 1);
        tick();
        check("t2_resp_done", rsp_valid, 0);
        r0_valid = 1'b1;
        #1;
        check("t2_idle_ready", r0_ready, 1);
        r0_valid = 1'b0;

        // 3: both valid after reset, grants alternate 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        r0_valid = 1'b1; r0_op = 4'b0011; r0_a = 32'd1;  r0_b = 32'd1;
        r1_valid = 1'b1; r1_op = 4'b0101; r1_a = 32'd41; r1_b = 32'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_req0_ready", r0_ready, (i % 2 == 0) ? 1 : 0);
            check("t3_req1_ready", r1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            tick();
            check("t3_resp_valid", rsp_valid, 1);
            check("t3_resp_id", rsp_id, i % 2);
            check("t3_resp_result", rsp_result, (i % 2 == 0) ? 32'd2 : 32'd42);
            tick();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // 4: backpressure; requester 1 stays valid and must not be accepted while RESP waits
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = 4'b0000; r0_a = 32'h0000F0F0; r0_b = 32'h0000FF00;
        r1_valid = 1'b1; r1_op = 4'b0001; r1_a = 32'd1;        r1_b = 32'd2;
        #1;
        check("t4_req0_ready", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_result", rsp_result, 32'h0000F000);
            check("t4_hold_id", rsp_id, 0);
            check("t4_hold_zero", rsp_zero, 0);
            check("t4_hold_req0_ready", r0_ready, 0);
            check("t4_hold_req1_ready", r1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_still_valid", rsp_valid, 1);
        tick();
        check("t4_consumed", rsp_valid, 0);
        check("t4_req1_ready", r1_ready, 1);
        tick();
        r1_valid = 1'b0;
        tick();
        check("t4_or_result", rsp_result, 32'd3);
        check("t4_or_id", rsp_id, 1);
        tick();

        // 5: EXEC_CYCLES=3 MOV
        srsp_ready = 1'b1;
        s0_valid = 1'b1; s0_op = 4'b0111; s0_a = 32'd0; s0_b = 32'hDEADBEEF;
        #1;
        check("t5_ready", s0_ready, 1);
        tick();
        s0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_alu_op", b_op, 4'b0111);
            check("t5_alu_a", b_a, 32'd0);
            check("t5_alu_b", b_b, 32'hDEADBEEF);
            check("t5_not_yet", srsp_valid, 0);
            tick();
        end
        check("t5_resp_valid", srsp_valid, 1);
        check("t5_resp_result", srsp_result, 32'hDEADBEEF);
        check("t5_resp_zero", srsp_zero, 0);
        tick();
        check("t5_consumed", srsp_valid, 0);

        // 6: reset in EXEC
        r0_valid = 1'b1; r0_op = 4'b0011; r0_a = 32'd100; r0_b = 32'd23;
        tick();
        r1_valid = 1'b1; r1_op = 4'b0011; r1_a = 32'd1; r1_b = 32'd1;
        check("t6_in_exec_alu_a", a_a, 32'd100);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_resp_valid", rsp_valid, 0);
        check("t6_rst_req0_ready", r0_ready, 0);
        check("t6_rst_req1_ready", r1_ready, 0);
        check("t6_rst_alu_a", a_a, 0);
        check("t6_rst_alu_op", a_op, 0);
        check("t6_rst_result", rsp_result, 0);
        check("t6_rst_id", rsp_id, 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t6_no_stale", rsp_valid, 0);
        r0_valid = 1'b1; r0_op = 4'b0001; r0_a = 32'd8; r0_b = 32'd1;
        r1_valid = 1'b1;
        #1;
        check("t6_req0_first", r0_ready, 1);
        check("t6_req1_waits", r1_ready, 0);
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        check("t6_result", rsp_result, 32'd9);
        check("t6_id", rsp_id, 0);
        tick();

        // Undefined opcode -> ALU returns 0, zero flag set
        r0_valid = 1'b1; r0_op = 4'b1111; r0_a = 32'd5; r0_b = 32'd5;
        tick();
        r0_valid = 1'b0;
        tick();
        check("undef_result", rsp_result, 0);
        check("undef_zero", rsp_zero, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester arbiter and sequencer that time-shares one instance of the team's combinational 32-bit ALU (4-bit opcode; AND/OR/NOR/ADD/SUB/INC/MULTPLUS/MOV/ADDI) between two clients.
- Accepts operation requests through valid/ready handshakes and grants round-robin.
- Holds ALU inputs stable for a programmable settle time, then registers the result and zero flag.
- Returns result plus requester ID on a single response channel with backpressure.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, ALU opcode width
EXEC_CYCLES, 1, cycles ALU inputs are held before capture; legal 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_op  input  OP_WIDTH  requester 0 ALU opcode
req0_a  input  DATA_WIDTH  requester 0 operand A
req0_b  input  DATA_WIDTH  requester 0 operand B
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0, for requester 1
alu_op  output  OP_WIDTH  to ALU ALUOperation
alu_a  output  DATA_WIDTH  to ALU A
alu_b  output  DATA_WIDTH  to ALU B
alu_result  input  DATA_WIDTH  from ALU ALUResult
alu_zero  input  1  from ALU Zero
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_id  output  1  requester that issued the operation (0/1)
resp_result  output  DATA_WIDTH  registered ALU result
resp_zero  output  1  registered zero flag

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, any state, including mid-operation): state=IDLE, last_grant=1, counter=0. Operand registers, alu_op/alu_a/alu_b, resp_result, resp_zero, resp_id = 0. resp_valid=0. In-flight operation discarded silently.
- alu_op/alu_a/alu_b are always driven from operand registers, never combinationally from request ports, so they hold last values in IDLE and RESP.
- Arbitration in IDLE only:
  - Single valid requester wins.
  - Both valid: winner is the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid, combinational.
  - Both readys are 0 outside IDLE.
  - Requesters must not make valid depend on ready, and must hold valid/op/a/b until accepted.
- Accept (valid&&ready at a rising edge):
  - Latch op/a/b into operand registers; latch resp_id=N.
  - last_grant=N.
  - counter=EXEC_CYCLES-1.
  - Go to EXEC.
- EXEC: counter decrements each cycle. At the edge where counter==0, capture alu_result into resp_result and alu_zero into resp_zero, then go to RESP. resp_valid rises exactly EXEC_CYCLES edges after the accept edge.
- RESP: resp_valid=1, with resp_* held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE, resp_valid=0 next cycle. There is no accept in the handshake cycle.
- Throughput: one operation per EXEC_CYCLES+2 cycles minimum.
- Opcodes are passed through unchecked. Undefined opcodes yield ALU result 0, so resp_zero=1. Arithmetic width and overflow are owned entirely by the ALU.
- No request is ever dropped. A requester continuously valid is served within one other operation (no starvation).

Test Plan:
1. Reset, EXEC_CYCLES=1; req0 op=4'b0011 a=5 b=7 -> req0_ready=1 that cycle; one edge later resp_valid=1, resp_id=0, resp_result=12, resp_zero=0.
2. req1 op=4'b0100 a=9 b=9, resp_ready=1 -> resp_result=0, resp_zero=1, resp_id=1; FSM back in IDLE next cycle.
3. Both valid right after reset (req0 op=0011 a=1 b=1; req1 op=0101 a=41) -> req0 served first (result 2), then req1 (result 42). With both held valid, grants alternate 0,1,0,1.
4. Backpressure: resp_ready=0 for 4 cycles after resp_valid -> resp_result/resp_id/resp_zero stable, both req readys 0; response consumed on the first resp_ready=1 edge.
5. EXEC_CYCLES=3; op=0111 b=32'hDEADBEEF -> alu_a/alu_b/alu_op stable for 3 cycles; resp_valid rises 3 edges after accept; result 32'hDEADBEEF.
6. Assert reset during EXEC -> immediately resp_valid=0, readys 0, outputs 0. After release, req0 wins first and no stale response appears.
